divider_128bits_seq: RTL and testbench
======================================

# divider_128bits_seq

Sequential restoring divider that inverts the 64x64 multipliers: it accepts a 128-bit dividend (a multiplier product) and a 64-bit divisor, and returns a 64-bit quotient and a 64-bit remainder. It computes one quotient bit per clock, so it trades the multipliers' wide combinational array for a small shift/subtract datapath. It sits beside the multiplier family as the round-trip checker and as the divide unit for the same operand widths. Handshake is start/done with a ready indication.

## Interface
- WIDTH, 64: divisor, quotient and remainder width; dividend is 2*WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when ready=1.
- dividend  in  2*WIDTH  numerator, unsigned; sampled with start.
- divisor  in  WIDTH  denominator, unsigned; sampled with start.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse: results valid.
- quotient  out  WIDTH  unsigned quotient.
- remainder  out  WIDTH  unsigned remainder.
- div_by_zero  out  1  divisor was 0 for the completed operation.
- overflow  out  1  quotient does not fit in WIDTH bits, i.e. dividend[2W-1:W] >= divisor and divisor != 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start, latch the operands, clear both flags, then branch:
  - divisor==0: set div_by_zero, quotient=all ones, remainder=dividend[W-1:0], go to DONE.
  - overflow condition: set overflow, quotient=all ones, remainder=0, go to DONE.
  - otherwise: R=dividend[2W-1:W] (guaranteed < divisor), Q=dividend[W-1:0], count=W-1, go to RUN.
- RUN, each cycle:
  - Form T = {R,Q[W-1]} as W+1 bits and shift Q left.
  - If T >= divisor, then R=T-divisor and the new Q lsb=1. Else R=T[W-1:0] and the new Q lsb=0.
  - The compare and subtract are W+1 bits wide. The result always fits in W bits because R<divisor holds on every cycle.
  - At count==0 go to DONE. Otherwise decrement count.
- DONE: done=1 for exactly one cycle, quotient=Q, remainder=R, ready=0. Next state is IDLE.
- Results and flags hold their values from DONE until the next accepted start.
- start while ready=0 (RUN or DONE) is ignored and is not queued.
- Invariant on normal completion: quotient*divisor + remainder == dividend, with remainder < divisor.

## Timing
- Reset values: ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state IDLE, count=0.
- Reset takes effect asynchronously at any time, including mid-RUN: the operation is abandoned, no done is issued, and all outputs return to their reset values.
- Call the start acceptance edge cycle 0.
- Normal operation: RUN occupies cycles 1..W. done=1 in cycle W+1, which is 65 for W=64. ready returns to 1 in cycle W+2.
- Error paths (divisor zero, overflow): done=1 in cycle 1, ready=1 in cycle 2.
- ready goes low in the cycle after acceptance.
- Back-to-back throughput: one operation per W+2 cycles. start may be held high continuously; it is accepted in each IDLE cycle.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- dividend=100, divisor=7 -> done in cycle 65, quotient=14, remainder=2, both flags 0. ready=0 during cycles 1-65.
- Round trip: dividend=128'hFFFFFFFFFFFFFFFE_0000000000000001, divisor=64'hFFFFFFFFFFFFFFFF -> quotient=64'hFFFFFFFFFFFFFFFF, remainder=0.
- Multiplier round trip: dividend = 64'h5829EC10 * 64'h123BBBCF00000000, divisor=64'h123BBBCF00000000 -> quotient=64'h5829EC10, remainder=0. Then feed the same product with divisor=64'h5829EC10 -> quotient=64'h123BBBCF00000000, remainder=0.
- Errors:
  - divisor=0, dividend=128'h1234 -> done in cycle 1, div_by_zero=1, quotient=all ones, remainder=64'h1234.
  - dividend=128'h5_0000000000000000, divisor=5 -> done in cycle 1, overflow=1, quotient=all ones, remainder=0.
- Start ignored while busy: pulse start with new operands at cycles 10 and 65 -> the first result is unchanged and no second operation runs. Then start in IDLE -> accepted normally.
- Reset mid-operation: assert rst_n=0 in cycle 30 -> outputs return to reset values immediately and no done pulse appears. After release, a new divide of 100/7 completes correctly in 65 cycles.

Source files
------------

// File: rtl/divider_128bits_seq.sv
// divider_128bits_seq
//
// Sequential restoring divider: 2*WIDTH-bit unsigned dividend by WIDTH-bit
// unsigned divisor, one quotient bit per clock. It is the inverse of the
// WIDTHxWIDTH multipliers, so a product fed back in with either factor as
// the divisor returns the other factor with a zero remainder.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request, sampled only while ready=1
//   dividend     2*WIDTH-bit numerator, captured with start
//   divisor      WIDTH-bit denominator, captured with start
//   ready        idle, able to accept start
//   done         one-cycle pulse, results valid
//   quotient     WIDTH-bit quotient (all ones on divide-by-zero or overflow)
//   remainder    WIDTH-bit remainder
//   div_by_zero  divisor was zero for the completed operation
//   overflow     quotient would not fit in WIDTH bits
//
// Latency from the accepting edge (cycle 0): done in cycle WIDTH+1 for a
// normal divide, cycle 1 for the error paths. All outputs are registered.
module divider_128bits_seq #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  r;        // partial remainder, always < dvsr while running
  logic [WIDTH-1:0]  q;        // dividend low half shifting out, quotient shifting in
  logic [WIDTH-1:0]  dvsr;     // captured divisor
  logic [CW-1:0]     count;    // remaining iterations minus one

  logic              accept;
  logic              is_zero;
  logic              is_ovf;
  logic [WIDTH-1:0]  div_hi;
  logic [WIDTH-1:0]  div_lo;
  logic [WIDTH:0]    t;        // {r, next dividend bit}, one bit wider than r
  logic              ge;
  logic [WIDTH-1:0]  r_step;
  logic [WIDTH-1:0]  q_step;

  assign div_hi  = dividend[2*WIDTH-1:WIDTH];
  assign div_lo  = dividend[WIDTH-1:0];
  assign accept  = (state == IDLE) && start;
  assign is_zero = (divisor == '0);
  // A quotient fits in WIDTH bits only when the high half is below the divisor.
  assign is_ovf  = !is_zero && (div_hi >= divisor);

  // One restoring step. The compare needs the extra top bit of t, but since
  // r < dvsr the difference always fits in WIDTH bits, so the subtraction
  // can be done modulo 2**WIDTH on the low bits.
  assign t      = {r, q[WIDTH-1]};
  assign ge     = (t >= {1'b0, dvsr});
  assign r_step = ge ? (t[WIDTH-1:0] - dvsr) : t[WIDTH-1:0];
  assign q_step = {q[WIDTH-2:0], ge};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (is_zero || is_ovf) ? DONE : RUN;
      RUN:  if (count == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      // ready/done are decoded from the next state so they stay registered.
      ready <= (state_nxt == IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      dvsr        <= divisor;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      if (is_zero) begin
        div_by_zero <= 1'b1;
        quotient    <= '1;
        remainder   <= div_lo;
      end else if (is_ovf) begin
        overflow    <= 1'b1;
        quotient    <= '1;
        remainder   <= '0;
      end else begin
        r     <= div_hi;
        q     <= div_lo;
        count <= CW'(WIDTH - 1);
      end
    end else if (state == RUN) begin
      r <= r_step;
      q <= q_step;
      if (count == '0) begin
        // Publish on the last step so the results are valid together with done
        // and then hold until the next accepted start.
        quotient  <= q_step;
        remainder <= r_step;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider_128bits_seq.sv
// Self-checking bench for divider_128bits_seq: directed operations with a
// scoreboard queue of expected results, popped when done pulses.
module tb_divider_128bits_seq;

  localparam int W      = 64;
  localparam int LAT    = W + 1;  // done cycle for a normal divide
  localparam int LAT_ER = 1;      // done cycle for error paths

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           ready;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  divider_128bits_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, follow it to done and compare against the scoreboard.
  // With poke set, new operands are pulsed at cycle 10 and in the done cycle;
  // both must be ignored.
  task automatic run_op(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input logic eovf, input int elat, input bit poke);
    exp_t e;
    int   cyc;
    int   ready_bad;
    bit   seen;
    sb.push_back('{q: eq, r: er, dbz: edbz, ovf: eovf, lat: elat});
    check({name, ".ready_in"}, 128'(ready), 128'(1'b1));
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    ready_bad = 0;
    forever begin
      if (ready) ready_bad++;
      if (done && !seen) begin
        seen = 1'b1;
        e = sb.pop_front();
        check({name, ".latency"}, 128'(cyc), 128'(e.lat));
        check({name, ".quotient"}, 128'(quotient), 128'(e.q));
        check({name, ".remainder"}, 128'(remainder), 128'(e.r));
        check({name, ".div_by_zero"}, 128'(div_by_zero), 128'(e.dbz));
        check({name, ".overflow"}, 128'(overflow), 128'(e.ovf));
      end
      if (poke && (cyc == 10 || cyc == elat)) begin
        start    = 1'b1;
        dividend = 128'd555;
        divisor  = 64'd2;
      end
      if (seen || cyc >= elat + 5) break;
      tick();
      start = 1'b0;
      cyc++;
    end
    check({name, ".done_seen"}, 128'(seen), 128'(1'b1));
    check({name, ".ready_busy"}, 128'(ready_bad), 128'(0));
    tick();
    start = 1'b0;
    check({name, ".done_pulse"}, 128'(done), 128'(1'b0));
    check({name, ".ready_after"}, 128'(ready), 128'(1'b1));
    check({name, ".hold_q"}, 128'(quotient), 128'(eq));
  endtask

  initial begin
    logic [2*W-1:0] prod;
    int             done_cnt;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    check("reset.ready", 128'(ready), 128'(1'b1));
    check("reset.done", 128'(done), 128'(1'b0));
    check("reset.quotient", 128'(quotient), 128'(0));
    check("reset.remainder", 128'(remainder), 128'(0));
    check("reset.div_by_zero", 128'(div_by_zero), 128'(1'b0));
    check("reset.overflow", 128'(overflow), 128'(1'b0));

    run_op("d100_7", 128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, LAT, 1'b0);

    run_op("max_sq", 128'hFFFFFFFFFFFFFFFE_0000000000000001, 64'hFFFFFFFFFFFFFFFF,
           64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b0, LAT, 1'b0);

    prod = 128'(64'h5829EC10) * 128'(64'h123BBBCF00000000);
    run_op("mul_rt_a", prod, 64'h123BBBCF00000000, 64'h5829EC10, 64'd0, 1'b0, 1'b0, LAT, 1'b0);
    run_op("mul_rt_b", prod, 64'h5829EC10, 64'h123BBBCF00000000, 64'd0, 1'b0, 1'b0, LAT, 1'b0);

    run_op("div_zero", 128'h1234, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1234, 1'b1, 1'b0, LAT_ER, 1'b0);
    run_op("ovf", 128'h5_0000000000000000, 64'd5, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b1, LAT_ER, 1'b0);

    // 1000 / 13 = 76 rem 12, with starts poked while busy.
    run_op("busy", 128'd1000, 64'd13, 64'd76, 64'd12, 1'b0, 1'b0, LAT, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("busy.no_second_op", 128'(done_cnt), 128'(0));
    check("busy.result_kept", 128'(quotient), 128'(64'd76));
    run_op("after_busy", 128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, LAT, 1'b0);

    // Reset in cycle 30 of a running divide.
    start    = 1'b1;
    dividend = 128'd1000;
    divisor  = 64'd13;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c < 30; c++) begin
      if (done) done_cnt++;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid.ready", 128'(ready), 128'(1'b1));
    check("rst_mid.done", 128'(done), 128'(1'b0));
    check("rst_mid.quotient", 128'(quotient), 128'(0));
    check("rst_mid.remainder", 128'(remainder), 128'(0));
    check("rst_mid.flags", 128'({div_by_zero, overflow}), 128'(2'b00));
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("rst_mid.no_done", 128'(done_cnt), 128'(0));
    run_op("after_rst", 128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, LAT, 1'b0);

    check("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
